// File: rtl/tcp_buf_ring_mgr.sv
// Per-flow TCP payload buffer descriptor rings: posts, message requests and index adjusts.
// Define TCP_BUF_PARTIAL_CONSUME_EN to honour leftover-byte (partial) consumption via ADJ_WR.
module tcp_buf_ring_mgr #(
    parameter  int NUM_FLOWS    = 16,
    parameter  int MAX_NUM_BUFS = 8,
    parameter  int PTR_W        = 32,
    localparam int FLOWID_W     = $clog2(NUM_FLOWS),
    localparam int IDX_W        = $clog2(MAX_NUM_BUFS),
    localparam int IW           = IDX_W + 1,
    localparam int LEN_W        = PTR_W + 1,
    localparam int BUF_W        = PTR_W + 2*LEN_W,
    localparam int RESP_W       = BUF_W + IW,
    localparam int UPD_W        = LEN_W + IW + RESP_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                post_val,
    output logic                post_rdy,
    input  logic [FLOWID_W-1:0] post_flowid,
    input  logic [BUF_W-1:0]    post_buf,
    output logic                post_err,
    input  logic                req_val,
    output logic                req_rdy,
    input  logic [FLOWID_W-1:0] req_flowid,
    output logic                resp_val,
    input  logic                resp_rdy,
    output logic [RESP_W-1:0]   resp_buf,
    output logic                resp_empty,
    input  logic                adj_val,
    output logic                adj_rdy,
    input  logic [FLOWID_W-1:0] adj_flowid,
    input  logic [UPD_W-1:0]    adj_update,
    output logic                adj_done,
    output logic                adj_err
);
    localparam int AW = FLOWID_W + IDX_W;

    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_RESP, S_ADJ_CHK
`ifdef TCP_BUF_PARTIAL_CONSUME_EN
        , S_ADJ_WR
`endif
    } state_e;

    state_e                          state_q, state_d;
    logic [NUM_FLOWS-1:0][IW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [FLOWID_W-1:0]             flow_q, flow_d;
    logic                            is_adj_q, is_adj_d;
    logic [LEN_W-1:0]                l_q, l_d;
    logic [IW-1:0]                   n_q, n_d, pidx_q, pidx_d;
    logic                            post_err_q, post_err_d;

    logic [BUF_W-1:0]                mem [NUM_FLOWS*MAX_NUM_BUFS];
    logic [BUF_W-1:0]                rd_data_q;
    logic                            ram_we, ram_re;
    logic [AW-1:0]                   ram_waddr, ram_raddr;
    logic [BUF_W-1:0]                ram_wdata;

    logic [IW-1:0] post_occ, cur_head, cur_tail, occ, rd_idx;
    logic          adj_bad;
    logic          unused_prev_info;

    assign post_occ  = head_q[post_flowid] - tail_q[post_flowid];
    assign cur_head  = head_q[flow_q];
    assign cur_tail  = tail_q[flow_q];
    assign occ       = cur_head - cur_tail;
    // Adjust reads the buffer that a partial consume would land on.
    assign rd_idx    = cur_tail + (is_adj_q ? n_q : '0);
    assign ram_raddr = {flow_q, rd_idx[IDX_W-1:0]};
    assign post_err  = post_err_q;
    assign unused_prev_info = ^adj_update[RESP_W-1:IW];

    always_comb begin
        adj_bad = (pidx_q != cur_tail) || (n_q > occ);
`ifdef TCP_BUF_PARTIAL_CONSUME_EN
        if (l_q != '0 && (n_q == occ || l_q >= rd_data_q[2*LEN_W-1 -: LEN_W])) adj_bad = 1'b1;
`else
        if (l_q != '0) adj_bad = 1'b1;
`endif
    end

    always_comb begin
        state_d    = state_q;
        head_d     = head_q;
        tail_d     = tail_q;
        flow_d     = flow_q;
        is_adj_d   = is_adj_q;
        l_d        = l_q;
        n_d        = n_q;
        pidx_d     = pidx_q;
        post_err_d = 1'b0;
        post_rdy   = 1'b0;
        req_rdy    = 1'b0;
        adj_rdy    = 1'b0;
        ram_we     = 1'b0;
        ram_re     = 1'b0;
        ram_waddr  = {post_flowid, head_q[post_flowid][IDX_W-1:0]};
        ram_wdata  = post_buf;
        resp_val   = 1'b0;
        resp_empty = 1'b0;
        resp_buf   = '0;
        adj_done   = 1'b0;
        adj_err    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (adj_val) begin
                    adj_rdy  = 1'b1;
                    flow_d   = adj_flowid;
                    is_adj_d = 1'b1;
                    l_d      = adj_update[UPD_W-1 -: LEN_W];
                    n_d      = adj_update[RESP_W +: IW];
                    pidx_d   = adj_update[IW-1:0];
                    state_d  = S_RD;
                end else if (post_val) begin
                    post_rdy = 1'b1;
                    if (post_occ == IW'(MAX_NUM_BUFS)) begin
                        post_err_d = 1'b1;
                    end else begin
                        ram_we              = 1'b1;
                        head_d[post_flowid] = head_q[post_flowid] + IW'(1);
                    end
                end else if (req_val) begin
                    req_rdy  = 1'b1;
                    flow_d   = req_flowid;
                    is_adj_d = 1'b0;
                    state_d  = S_RD;
                end
            end
            S_RD: begin
                ram_re  = 1'b1;
                state_d = is_adj_q ? S_ADJ_CHK : S_RESP;
            end
            S_RESP: begin
                resp_val = 1'b1;
                if (occ == '0) resp_empty = 1'b1;
                else           resp_buf   = {rd_data_q, cur_tail};
                if (resp_rdy) state_d = S_IDLE;
            end
            S_ADJ_CHK: begin
                state_d = S_IDLE;
                if (adj_bad) begin
                    adj_done = 1'b1;
                    adj_err  = 1'b1;
`ifdef TCP_BUF_PARTIAL_CONSUME_EN
                end else if (l_q != '0) begin
                    state_d = S_ADJ_WR;
`endif
                end else begin
                    adj_done       = 1'b1;
                    tail_d[flow_q] = cur_tail + n_q;
                end
            end
`ifdef TCP_BUF_PARTIAL_CONSUME_EN
            S_ADJ_WR: begin
                // Trim the partially consumed buffer in place; cap is untouched.
                ram_we    = 1'b1;
                ram_waddr = {flow_q, rd_idx[IDX_W-1:0]};
                ram_wdata = {rd_data_q[BUF_W-1 -: PTR_W] + l_q[PTR_W-1:0],
                             rd_data_q[2*LEN_W-1 -: LEN_W] - l_q,
                             rd_data_q[LEN_W-1:0]};
                tail_d[flow_q] = cur_tail + n_q;
                adj_done  = 1'b1;
                state_d   = S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            head_q     <= '0;
            tail_q     <= '0;
            flow_q     <= '0;
            is_adj_q   <= 1'b0;
            l_q        <= '0;
            n_q        <= '0;
            pidx_q     <= '0;
            post_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            flow_q     <= flow_d;
            is_adj_q   <= is_adj_d;
            l_q        <= l_d;
            n_q        <= n_d;
            pidx_q     <= pidx_d;
            post_err_q <= post_err_d;
        end
    end

    // Descriptor storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= ram_wdata;
        if (ram_re) rd_data_q <= mem[ram_raddr];
    end
endmodule

// File: tb/tb_tcp_buf_ring_mgr.sv
// Randomised self-checking bench for tcp_buf_ring_mgr against a counter-based ring model.
module tb_tcp_buf_ring_mgr;
    localparam int NF = 16, NB = 8;
    localparam int FW = 4, IW = 4, LW = 33, BW = 98, RW = 102, UW = 139;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          post_val = 1'b0, post_rdy, post_err;
    logic [FW-1:0] post_flowid = '0;
    logic [BW-1:0] post_buf = '0;
    logic          req_val = 1'b0, req_rdy;
    logic [FW-1:0] req_flowid = '0;
    logic          resp_val, resp_rdy = 1'b0, resp_empty;
    logic [RW-1:0] resp_buf;
    logic          adj_val = 1'b0, adj_rdy, adj_done, adj_err;
    logic [FW-1:0] adj_flowid = '0;
    logic [UW-1:0] adj_update = '0;

    tcp_buf_ring_mgr dut (
        .clk(clk), .rst_n(rst_n),
        .post_val(post_val), .post_rdy(post_rdy), .post_flowid(post_flowid),
        .post_buf(post_buf), .post_err(post_err),
        .req_val(req_val), .req_rdy(req_rdy), .req_flowid(req_flowid),
        .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_buf(resp_buf), .resp_empty(resp_empty),
        .adj_val(adj_val), .adj_rdy(adj_rdy), .adj_flowid(adj_flowid),
        .adj_update(adj_update), .adj_done(adj_done), .adj_err(adj_err)
    );

    always #5 clk = ~clk;

    int unsigned   vecs = 0, errs = 0;
    // Model: absolute produced/consumed counts per flow; slot = count mod ring depth.
    int unsigned   prod [NF];
    int unsigned   cons [NF];
    logic [BW-1:0] store [NF][NB];

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic model_reset();
        for (int f = 0; f < NF; f++) begin prod[f] = 0; cons[f] = 0; end
    endtask

    function automatic logic [BW-1:0] mkbuf(input logic [31:0] p, input logic [LW-1:0] l, input logic [LW-1:0] c);
        return {p, l, c};
    endfunction

    task automatic do_post(input int f, input logic [BW-1:0] b);
        bit full;
        full = (prod[f] - cons[f]) == NB;
        post_val = 1'b1; post_flowid = FW'(f); post_buf = b;
        @(negedge clk);
        vecs++; if (post_rdy !== 1'b1) begin errs++; $display("FAIL post_rdy f%0d: got %b want 1", f, post_rdy); end
        tick();
        post_val = 1'b0;
        vecs++; if (post_err !== full) begin errs++; $display("FAIL post_err f%0d: got %b want %b", f, post_err, full); end
        if (!full) begin store[f][prod[f] % NB] = b; prod[f]++; end
    endtask

    task automatic do_req(input int f, input int hold);
        logic [RW-1:0] exp_buf;
        bit            exp_empty;
        exp_empty = prod[f] == cons[f];
        exp_buf   = exp_empty ? '0 : {store[f][cons[f] % NB], IW'(cons[f] % 16)};
        req_val = 1'b1; req_flowid = FW'(f);
        @(negedge clk);
        vecs++; if (req_rdy !== 1'b1) begin errs++; $display("FAIL req_rdy f%0d: got %b want 1", f, req_rdy); end
        tick();
        req_val = 1'b0;
        @(negedge clk);
        vecs++; if (resp_val !== 1'b0) begin errs++; $display("FAIL resp_early f%0d: got %b want 0", f, resp_val); end
        tick();
        for (int i = 0; i <= hold; i++) begin
            if (i == hold) resp_rdy = 1'b1;
            @(negedge clk);
            vecs++; if (resp_val !== 1'b1 || resp_empty !== exp_empty || resp_buf !== exp_buf) begin
                errs++;
                $display("FAIL resp f%0d: got val=%b empty=%b buf=%h want val=1 empty=%b buf=%h",
                         f, resp_val, resp_empty, resp_buf, exp_empty, exp_buf);
            end
            tick();
        end
        resp_rdy = 1'b0;
    endtask

    task automatic do_adj(input int f, input int pidx, input int n, input logic [LW-1:0] l);
        bit            err, part;
        int unsigned   occ;
        logic [BW-1:0] d;
        occ = prod[f] - cons[f];
        d   = store[f][(cons[f] + n) % NB];
        err = ((pidx % 16) != (cons[f] % 16)) || (n > occ);
`ifdef TCP_BUF_PARTIAL_CONSUME_EN
        if (l != 0 && (n == occ || l >= d[65:33])) err = 1'b1;
`else
        if (l != 0) err = 1'b1;
`endif
        part = !err && l != 0;
        adj_val = 1'b1; adj_flowid = FW'(f);
        adj_update = {l, IW'(n), BW'({$urandom, $urandom, $urandom, $urandom}), IW'(pidx)};
        @(negedge clk);
        vecs++; if (adj_rdy !== 1'b1) begin errs++; $display("FAIL adj_rdy f%0d: got %b want 1", f, adj_rdy); end
        tick();
        adj_val = 1'b0;
        @(negedge clk);
        vecs++; if (adj_done !== 1'b0) begin errs++; $display("FAIL adj_early f%0d: got %b want 0", f, adj_done); end
        tick();
        @(negedge clk);
        vecs++; if (adj_done !== !part || adj_err !== err) begin
            errs++;
            $display("FAIL adj_t2 f%0d n=%0d l=%h: got done=%b err=%b want done=%b err=%b",
                     f, n, l, adj_done, adj_err, !part, err);
        end
        if (part) begin
            tick();
            @(negedge clk);
            vecs++; if (adj_done !== 1'b1 || adj_err !== 1'b0) begin
                errs++; $display("FAIL adj_t3 f%0d: got done=%b err=%b want done=1 err=0", f, adj_done, adj_err);
            end
        end
        tick();
        if (!err) begin
            if (part) begin
                d[97:66] = d[97:66] + l[31:0];
                d[65:33] = d[65:33] - l;
                store[f][(cons[f] + n) % NB] = d;
            end
            cons[f] += n;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        vecs++; if ({post_rdy, req_rdy, adj_rdy, post_err} !== 4'b0) begin
            errs++; $display("FAIL reset_rdy: got %b want 0000", {post_rdy, req_rdy, adj_rdy, post_err});
        end
        vecs++; if ({resp_val, resp_empty, adj_done, adj_err} !== 4'b0 || resp_buf !== '0) begin
            errs++; $display("FAIL reset_out: got %b buf=%h want 0", {resp_val, resp_empty, adj_done, adj_err}, resp_buf);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_empty_req();
        do_req(3, 0);
    endtask

    task automatic test_fill();
        for (int k = 0; k < 9; k++) do_post(1, mkbuf(32'(k * 'h1000), 33'h1000, 33'h1000));
        do_req(1, 1);
    endtask

    task automatic test_adjust();
        do_adj(1, 0, 3, '0);
        do_req(1, 0);
    endtask

    task automatic test_partial();
        do_adj(1, cons[1] % 16, 2, 33'h100);
        do_req(1, 0);
    endtask

    task automatic test_errors();
        do_adj(1, (cons[1] + 1) % 16, 0, '0);
        do_adj(1, (cons[1] + 8) % 16, 1, '0);
        do_adj(1, cons[1] % 16, prod[1] - cons[1] + 1, '0);
        do_adj(1, cons[1] % 16, prod[1] - cons[1], 33'h10);
        do_adj(1, cons[1] % 16, 0, 33'h2000);
        do_adj(1, cons[1] % 16, 0, '0);
        do_req(1, 0);
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 12; i++) begin
            do_post(2, mkbuf($urandom, LW'($urandom_range(1, 'h1000)), LW'($urandom)));
            do_req(2, $urandom_range(0, 2));
            if (i == 11) begin
                vecs++; if (resp_val !== 1'b0) begin errs++; $display("FAIL wrap_idle: got %b want 0", resp_val); end
                do_adj(2, 4'b0011, 1, '0);
            end
            do_adj(2, cons[2] % 16, 1, '0);
        end
    endtask

    task automatic test_priority();
        bit post_seen = 1'b0, req_early = 1'b0;
        int post_cyc = 0;
        adj_val = 1'b1; adj_flowid = 4'd1;
        adj_update = {33'h0, 4'h0, 98'h0, IW'(cons[1] % 16)};
        post_val = 1'b1; post_flowid = 4'd4; post_buf = mkbuf(32'hCAFE_0000, 33'h40, 33'h80);
        req_val = 1'b1; req_flowid = 4'd4;
        @(negedge clk);
        vecs++; if ({adj_rdy, post_rdy, req_rdy} !== 3'b100) begin
            errs++; $display("FAIL prio_rdy: got %b want 100", {adj_rdy, post_rdy, req_rdy});
        end
        tick();
        adj_val = 1'b0;
        for (int c = 1; c <= 12 && !post_seen; c++) begin
            @(negedge clk);
            if (c == 2) begin
                vecs++; if (adj_done !== 1'b1 || adj_err !== 1'b0) begin
                    errs++; $display("FAIL prio_adj: got done=%b err=%b want 1 0", adj_done, adj_err);
                end
            end
            if (post_rdy === 1'b1) begin post_seen = 1'b1; post_cyc = c; end
            if (req_rdy === 1'b1) req_early = 1'b1;
            tick();
        end
        post_val = 1'b0;
        vecs++; if (!post_seen || post_cyc != 3 || req_early) begin
            errs++; $display("FAIL prio_post: got seen=%b cyc=%0d req_early=%b want seen=1 cyc=3 req_early=0",
                             post_seen, post_cyc, req_early);
        end
        vecs++; if (post_err !== 1'b0) begin errs++; $display("FAIL prio_post_err: got %b want 0", post_err); end
        store[4][prod[4] % NB] = post_buf; prod[4]++;
        do_req(4, 0);
    endtask

    task automatic test_random();
        for (int it = 0; it < 400; it++) begin
            int f, op, pidx, n;
            logic [LW-1:0] l;
            f  = $urandom_range(0, 3);
            op = $urandom_range(0, 9);
            if (op < 4) begin
                do_post(f, mkbuf($urandom, LW'($urandom_range(1, 'h1000)), LW'($urandom)));
            end else if (op < 6) begin
                do_req(f, $urandom_range(0, 2));
            end else begin
                pidx = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : cons[f] % 16;
                n    = $urandom_range(0, prod[f] - cons[f] + 1);
                l    = ($urandom_range(0, 1) == 0) ? '0 : LW'($urandom_range(1, 'h1200));
                do_adj(f, pidx, n, l);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_post(5, mkbuf(32'h5555_0000, 33'h20, 33'h20));
        req_val = 1'b1; req_flowid = 4'd5;
        tick();
        req_val = 1'b0;
        tick();
        @(negedge clk);
        vecs++; if (resp_val !== 1'b1) begin errs++; $display("FAIL mid_resp: got %b want 1", resp_val); end
        #1 rst_n = 1'b0;
        #1;
        vecs++; if (resp_val !== 1'b0 || resp_buf !== '0) begin
            errs++; $display("FAIL mid_reset: got val=%b buf=%h want 0", resp_val, resp_buf);
        end
        model_reset();
        tick();
        rst_n = 1'b1;
        tick();
        do_req(5, 0);
    endtask

    initial begin
        test_reset();
        test_empty_req();
        test_fill();
        test_adjust();
        test_partial();
        test_errors();
        test_wrap();
        test_priority();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end
endmodule
